// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the 16 x 32-bit instruction memory.
//
// Takes a byte stream over a valid/ready handshake. The first byte is the
// word count N, and N must be in 1..NUM_WORDS. Each following group of four
// bytes is packed little-endian into one 32-bit word. The words are written
// to the memory in order, starting at address 0. The processor core is held
// in reset until a load finishes without error.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When it is defined, one trailing byte follows the data and must equal the
//   modulo-256 sum of all data bytes. When it is undefined, the CHECK state
//   and all checksum logic are left out.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   load_start  one-cycle pulse that starts a (re)load
//   rx_valid    a byte is present on rx_data
//   rx_data     stream byte
//   rx_ready    loader accepts a byte this cycle (decoded from state)
//   imem_we     instruction memory write strobe, one cycle wide
//   imem_addr   write word address
//   imem_wdata  write word
//   core_hold   high holds the processor in reset
//   done        load completed successfully (sticky)
//   error       load aborted or failed (sticky)
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// COUNT | waiting for the word-count byte
// DATA  | receiving data bytes and writing words
// CHECK | waiting for the checksum byte (checksum build only)
// DONE  | load good, core released
// ERR   | load failed, core held
module imem_loader #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] n_words;
    logic [23:0]      word_lo;
    logic             accept;
    logic [CNT_W-1:0] word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
    assign rx_ready = (state == COUNT) || (state == DATA) || (state == CHECK);
`else
    assign rx_ready = (state == COUNT) || (state == DATA);
`endif

    assign accept    = rx_valid && rx_ready;
    assign word_next = word_idx + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_idx   <= '0;
            n_words    <= '0;
            word_lo    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if ((rx_data == 8'd0) || (rx_data > 8'(NUM_WORDS))) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            n_words  <= rx_data[CNT_W-1:0];
                            byte_cnt <= '0;
                            word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum + rx_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // The fourth byte completes the word. The write is
                            // registered, so it lands one cycle after this byte.
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, word_lo};
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            word_idx   <= word_next;
                            if (word_next == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= CHECK;
`else
                                state     <= DONE;
                                done      <= 1'b1;
                                core_hold <= 1'b0;
`endif
                            end
                        end else begin
                            word_lo[8*byte_cnt +: 8] <= rx_data;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    if (load_start) begin
                        state     <= COUNT;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        core_hold <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;

    // Write log filled by the monitor below.
    logic [3:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;
    logic        prev_we = 1'b0;
    logic        double_we = 1'b0;
    logic [7:0]  tb_sum;

    imem_loader #(.ADDR_W(4), .NUM_WORDS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (prev_we) double_we = 1'b1;
        end
        prev_we = imem_we;
    end

    // Called just after a negedge. Returns just after the negedge that follows
    // the accepting posedge. rx_valid stays high so calls can run back to back.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        logic acc;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        forever begin
            acc = rx_ready;
            @(negedge clk);
            if (acc) break;
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL send_byte timeout: byte %02h not accepted, rx_ready=%b, required 1", b, rx_ready);
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            tb_sum = tb_sum + w[8*k +: 8];
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        tb_sum = 8'd0;
    endtask

    task automatic send_check();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_sum, 0);
`endif
    endtask

    task automatic check_status(input string name, input logic exp_hold, input logic exp_done,
                                input logic exp_err, input logic exp_rdy);
        vectors++;
        if ({core_hold, done, error, rx_ready} !== {exp_hold, exp_done, exp_err, exp_rdy}) begin
            miscompares++;
            $display("FAIL %s: hold/done/err/rdy=%b%b%b%b, required %b%b%b%b", name,
                     core_hold, done, error, rx_ready, exp_hold, exp_done, exp_err, exp_rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_status("reset_status", 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_wr: we=%b addr=%h data=%h, required 0/0/0", imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_single_word();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'h00011020, 0);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'h0, 32'h00011020}) begin
            miscompares++;
            $display("FAIL single_write: we=%b addr=%h data=%h, required 1/0/00011020", imem_we, imem_addr, imem_wdata);
        end
        vectors++;
        if (tb_sum !== 8'h31) begin
            miscompares++;
            $display("FAIL single_sum: %02h, required 31", tb_sum);
        end
        send_check();
        rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (wr_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL single_count: %0d writes, required 1", wr_cnt - base);
        end
        check_status("single_done", 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_random();
        int base;
        int bad;
        base = wr_cnt;
        pulse_start();
        send_byte(8'd16, 1);
        for (int i = 0; i < 16; i++) send_word(32'(i), 2);
        send_check();
        rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (wr_cnt - base !== 16) begin
            miscompares++;
            $display("FAIL full_count: %0d writes, required 16", wr_cnt - base);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if ((base + i < 64) && ((wr_addr[base+i] !== 4'(i)) || (wr_data[base+i] !== 32'(i)))) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_data: %0d bad writes, required 0", bad);
        end
        check_status("full_done", 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_count();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        check_status("count_zero", 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_start();
        check_status("restart_clears", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h11, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        check_status("count_17", 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (wr_cnt !== base) begin
            miscompares++;
            $display("FAIL bad_count_nowrite: %0d writes, required 0", wr_cnt - base);
        end
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'hDEADBEEF, 0);
        send_check();
        rx_valid = 1'b0;
        @(negedge clk);
        check_status("recover_done", 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ((wr_cnt - base !== 1) || (wr_data[base] !== 32'hDEADBEEF)) begin
            miscompares++;
            $display("FAIL recover_write: %0d writes data %h, required 1 write DEADBEEF", wr_cnt - base, wr_data[base]);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'h00011020, 0);
        send_byte(8'h30, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ((wr_cnt - base !== 1) || (wr_data[base] !== 32'h00011020)) begin
            miscompares++;
            $display("FAIL csum_write: %0d writes data %h, required 1 write 00011020", wr_cnt - base, wr_data[base]);
        end
        check_status("csum_err", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_reset_midload();
        int base;
        int bad;
        pulse_start();
        send_byte(8'h04, 0);
        send_word(32'hC3005A00, 0);
        send_word(32'hC3005A01, 0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, core_hold, done, error, rx_ready} !== {1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midload_reset: we=%b addr=%h data=%h hold=%b done=%b err=%b rdy=%b, required 0/0/0/1/0/0/0",
                     imem_we, imem_addr, imem_wdata, core_hold, done, error, rx_ready);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        pulse_start();
        send_byte(8'h04, 0);
        for (int i = 0; i < 4; i++) send_word(32'hC3005A00 | 32'(i), 0);
        send_check();
        rx_valid = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if ((base + i < 64) && ((wr_addr[base+i] !== 4'(i)) || (wr_data[base+i] !== (32'hC3005A00 | 32'(i))))) bad++;
        end
        vectors++;
        if ((wr_cnt - base !== 4) || (bad != 0)) begin
            miscompares++;
            $display("FAIL reload: %0d writes %0d bad, required 4 writes 0 bad", wr_cnt - base, bad);
        end
        check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tb_sum     = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_full_random();
        test_bad_count();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_reset_midload();
        vectors++;
        if (double_we !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_we: %b, required 0", double_we);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
